operand_scoreboard: RTL
=======================

# operand_scoreboard

Decode-stage consumer of the general register file. Drives the two GRF read addresses and tracks every in-flight register write in the E, M and W stages. From that tracking it returns forwarded, up-to-date rs/rt operand values. It raises `stall` when an operand will not be ready by the time the decoded instruction needs it. It sits between the decoder/D-stage register and the GRF; the datapath supplies the per-stage result buses.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers. Register 0 is hard-wired zero.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears the scoreboard immediately.
- `issue_valid`  in  1  D-stage instruction is valid and advances to E when `stall`=0.
- `rs`, `rt`  in  5 each  source register numbers.
- `tuse_rs`, `tuse_rt`  in  2 each  cycles until the operand is consumed: 0 = D (branch compare), 1 = E, 2 = M (store data), 3 = unused.
- `dst`  in  5  destination register of the D instruction.
- `dst_we`  in  1  D instruction writes `dst`.
- `tnew`  in  2  cycles after entering E until the result exists: 0 = E (link address), 1 = M (ALU), 2 = W (load).
- `grf_a1`, `grf_a2`  out  5 each  GRF read addresses; always equal to `rs`, `rt`.
- `grf_rd1`, `grf_rd2`  in  DW each  GRF asynchronous read data.
- `fwd_e_data`, `fwd_m_data`, `fwd_w_data`  in  DW each  result buses of E, M, W.
- `rs_val`, `rt_val`  out  DW each  forwarded operand values (combinational).
- `stall`  out  1  freeze PC and D-stage register; insert a bubble into E.

## Operation
- The scoreboard holds 3 entries (E, M, W), each with fields `{we, dst[4:0], cnt[1:0]}`.
- Rising edge, `stall`=0:
  - E ← `{issue_valid & dst_we & (dst≠0), dst, tnew}`.
  - M ← E with `cnt` decremented, saturating at 0.
  - W ← M with `cnt` decremented, saturating at 0.
  - The old W entry retires; from then on the GRF holds the value.
- Rising edge, `stall`=1: E ← bubble `{0,0,0}`. M and W advance as above. The D inputs are held upstream.
- Per-operand lookup runs identically for rs and rt with register r and tuse u:
  - If u=3 or r=0: no hazard. The value is `grf_rdX`, which reads 0 for r=0.
  - Otherwise, find the youngest entry (priority E > M > W) with `we`=1 and `dst`=r.
  - No match: value = `grf_rdX`.
  - Match with `cnt` > u: hazard, and the operand requests a stall.
  - Match with `cnt`=0: value = that stage's `fwd_*_data`.
  - Match with 0 < `cnt` ≤ u: no stall. The value output is don't-care this cycle; the later stage re-forwards.
- `stall` = rs hazard OR rt hazard. It is forced to 0 while `reset`=1.
- W forwarding is mandatory. The GRF writes on the same edge that retires W, and the GRF has no internal write-to-read bypass.
- `tnew` values of 3 are illegal and are treated as 2.

## Timing
- Reset: all entries become `{0,0,0}` asynchronously, so `stall`=0. `grf_a1`/`grf_a2` follow `rs`/`rt`. `rs_val`/`rt_val` = `grf_rd1`/`grf_rd2`.
- The lookup path is purely combinational, with zero latency from `rs`/`rt`/`tuse`/the forward buses to `rs_val`/`rt_val`/`stall`.
- A producer with tnew=t and a consumer with tuse=u issued k cycles later stall for max(0, t−u−k+1) cycles.
- Reset asserted mid-stall: the pending hazard is dropped. There is no memory of stall state outside the entries.
- Simultaneous matches in several stages: the youngest (E) always wins, even if its `cnt`>0. An older, ready copy is never used.

## Structure
- Shared CPU package holds:
  - `TUSE_D`/`TUSE_E`/`TUSE_M`/`TUSE_NONE` encodings.
  - `TNEW_E`/`TNEW_M`/`TNEW_W` encodings.
  - the scoreboard entry typedef `{we, dst, cnt}`.
- One sub-module, `operand_forward`, is instantiated twice (rs, rt). It takes the three entries, the register number, tuse, the GRF data and the forward buses, and returns `{value, hazard}`.
- The top module owns the entry registers and the shift/bubble logic.

## Test plan
- Reset, then `rs`=5, tuse=1, no writers, `grf_rd1`=32'h1234 → `rs_val`=32'h1234, `stall`=0. Asserting `reset` mid-run empties all entries on the same cycle.
- ALU writer dst=8, tnew=1; next cycle consumer rs=8, tuse=1 → `stall`=0. E has cnt=1 ≤ 1. One cycle later the M entry has cnt=0 and `rs_val`=`fwd_m_data`.
- Load dst=9, tnew=2; next cycle consumer rt=9, tuse=1 → `stall`=1 for exactly 1 cycle, bubble in E. Then `rt_val`=`fwd_w_data`=32'hCAFE.
- Load dst=4, tnew=2; next cycle branch rs=4, tuse=0 → `stall`=1 for 2 cycles. Then `rs_val` comes from W.
- ALU dst=3 followed by ALU dst=3 (values 11, 22); consumer rs=3 issued next → forward returns 22 from M, never 11 from W.
- Writer with dst=0 and `dst_we`=1; consumer rs=0, tuse=0 → `stall`=0, `rs_val`=0. Also: store with tuse_rt=2 after a load to the same reg → no stall.

Source files
------------

// File: rtl/operand_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// operand_scoreboard_pkg
// Shared CPU encodings for operand-use timing (tuse), result-ready timing
// (tnew), and the in-flight writer entry tracked by the operand scoreboard.
// ---------------------------------------------------------------------------
package operand_scoreboard_pkg;

    localparam int REG_W = 5;

    // Stage in which a source operand is consumed, counted from D.
    localparam logic [1:0] TUSE_D    = 2'd0;
    localparam logic [1:0] TUSE_E    = 2'd1;
    localparam logic [1:0] TUSE_M    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Cycles after entering E until a result exists.
    localparam logic [1:0] TNEW_E = 2'd0;
    localparam logic [1:0] TNEW_M = 2'd1;
    localparam logic [1:0] TNEW_W = 2'd2;

    typedef struct packed {
        logic             we;
        logic [REG_W-1:0] dst;
        logic [1:0]       cnt;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // Remaining-cycles counter ages by one stage, never below zero.
    function automatic logic [1:0] cnt_dec(input logic [1:0] c);
        return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    // An illegal tnew of 3 behaves like a load.
    function automatic logic [1:0] tnew_clamp(input logic [1:0] t);
        return (t > TNEW_W) ? TNEW_W : t;
    endfunction

endpackage

// File: rtl/operand_scoreboard_forward.sv
// ---------------------------------------------------------------------------
// operand_forward
// Per-operand hazard lookup and forwarding mux.
// Ports:
//   ent_e_i/ent_m_i/ent_w_i  scoreboard entries of E, M, W
//   reg_i, tuse_i            source register and its use stage
//   grf_data_i               GRF read data for reg_i
//   fwd_e_i/fwd_m_i/fwd_w_i  per-stage result buses
//   value_o                  forwarded operand value
//   hazard_o                 operand cannot be supplied in time
// ---------------------------------------------------------------------------
module operand_forward
    import operand_scoreboard_pkg::*;
#(
    parameter int DW = 32
) (
    input  sb_entry_t        ent_e_i,
    input  sb_entry_t        ent_m_i,
    input  sb_entry_t        ent_w_i,
    input  logic [REG_W-1:0] reg_i,
    input  logic [1:0]       tuse_i,
    input  logic [DW-1:0]    grf_data_i,
    input  logic [DW-1:0]    fwd_e_i,
    input  logic [DW-1:0]    fwd_m_i,
    input  logic [DW-1:0]    fwd_w_i,
    output logic [DW-1:0]    value_o,
    output logic             hazard_o
);

    logic          hit;
    logic [1:0]    hit_cnt;
    logic [DW-1:0] hit_data;

    // Youngest matching writer wins, even when an older copy is already ready.
    always_comb begin
        hit      = 1'b0;
        hit_cnt  = 2'd0;
        hit_data = '0;
        if (ent_e_i.we && ent_e_i.dst == reg_i) begin
            hit      = 1'b1;
            hit_cnt  = ent_e_i.cnt;
            hit_data = fwd_e_i;
        end else if (ent_m_i.we && ent_m_i.dst == reg_i) begin
            hit      = 1'b1;
            hit_cnt  = ent_m_i.cnt;
            hit_data = fwd_m_i;
        end else if (ent_w_i.we && ent_w_i.dst == reg_i) begin
            hit      = 1'b1;
            hit_cnt  = ent_w_i.cnt;
            hit_data = fwd_w_i;
        end
    end

    // When 0 < cnt <= tuse the value is not yet valid, but a later stage
    // will re-forward it before use, so no stall is needed.
    always_comb begin
        value_o  = grf_data_i;
        hazard_o = 1'b0;
        if (tuse_i != TUSE_NONE && reg_i != '0 && hit) begin
            if (hit_cnt > tuse_i) begin
                hazard_o = 1'b1;
            end else if (hit_cnt == 2'd0) begin
                value_o = hit_data;
            end
        end
    end

endmodule

// File: rtl/operand_scoreboard.sv
// ---------------------------------------------------------------------------
// operand_scoreboard
// D-stage operand scoreboard: drives the GRF read addresses, tracks the
// in-flight writers of E/M/W, returns forwarded rs/rt values and raises
// stall when an operand will not be ready when it is needed.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   issue_valid, dst, dst_we,
//   tnew                       D-stage instruction's write description
//   rs, rt, tuse_rs, tuse_rt   D-stage source operands and use stages
//   grf_a1/grf_a2              GRF read addresses (= rs/rt)
//   grf_rd1/grf_rd2            GRF asynchronous read data
//   fwd_e/m/w_data             result buses of E, M, W
//   rs_val/rt_val              forwarded operand values
//   stall                      hold PC/D, insert bubble into E
// ---------------------------------------------------------------------------
module operand_scoreboard
    import operand_scoreboard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int DW   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [1:0]       tuse_rs,
    input  logic [1:0]       tuse_rt,
    input  logic [REG_W-1:0] dst,
    input  logic             dst_we,
    input  logic [1:0]       tnew,
    output logic [REG_W-1:0] grf_a1,
    output logic [REG_W-1:0] grf_a2,
    input  logic [DW-1:0]    grf_rd1,
    input  logic [DW-1:0]    grf_rd2,
    input  logic [DW-1:0]    fwd_e_data,
    input  logic [DW-1:0]    fwd_m_data,
    input  logic [DW-1:0]    fwd_w_data,
    output logic [DW-1:0]    rs_val,
    output logic [DW-1:0]    rt_val,
    output logic             stall
);

    sb_entry_t e_q, m_q, w_q;
    sb_entry_t e_d, m_d, w_d;
    logic      haz_rs, haz_rt;
    logic      dst_real;

    assign grf_a1 = rs;
    assign grf_a2 = rt;

    // Register 0 never creates a dependency; out-of-range numbers are ignored.
    assign dst_real = (dst != '0) && (int'({27'b0, dst}) < NREG);

    operand_forward #(.DW(DW)) u_fwd_rs (
        .ent_e_i    (e_q),
        .ent_m_i    (m_q),
        .ent_w_i    (w_q),
        .reg_i      (rs),
        .tuse_i     (tuse_rs),
        .grf_data_i (grf_rd1),
        .fwd_e_i    (fwd_e_data),
        .fwd_m_i    (fwd_m_data),
        .fwd_w_i    (fwd_w_data),
        .value_o    (rs_val),
        .hazard_o   (haz_rs)
    );

    operand_forward #(.DW(DW)) u_fwd_rt (
        .ent_e_i    (e_q),
        .ent_m_i    (m_q),
        .ent_w_i    (w_q),
        .reg_i      (rt),
        .tuse_i     (tuse_rt),
        .grf_data_i (grf_rd2),
        .fwd_e_i    (fwd_e_data),
        .fwd_m_i    (fwd_m_data),
        .fwd_w_i    (fwd_w_data),
        .value_o    (rt_val),
        .hazard_o   (haz_rt)
    );

    assign stall = ~reset & (haz_rs | haz_rt);

    // A stalled D instruction stays upstream; E receives a bubble instead.
    always_comb begin
        if (stall) begin
            e_d = SB_EMPTY;
        end else begin
            e_d.we  = issue_valid & dst_we & dst_real;
            e_d.dst = dst;
            e_d.cnt = tnew_clamp(tnew);
        end
        m_d     = e_q;
        m_d.cnt = cnt_dec(e_q.cnt);
        w_d     = m_q;
        w_d.cnt = cnt_dec(m_q.cnt);
    end

    // Old W retires each edge; the GRF takes over that value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q <= SB_EMPTY;
            m_q <= SB_EMPTY;
            w_q <= SB_EMPTY;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

endmodule
